// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locking arbiter that feeds one byte at a time from
// NUM_REQ requesters into a single uart_tx; a stalled packet owner is released after HOLD_TIMEOUT cycles.
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int HOLD_TIMEOUT = 16,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      arb_en_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      tx_busy_i,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    output logic                      gnt_valid_o,
    output logic [ID_W-1:0]           gnt_id_o,
    output logic                      pkt_abort_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic                tx_start_q;
    logic                gnt_valid_q;
    logic                pkt_abort_q;
    logic                last_q;
    logic [7:0]          hold_cnt_q;

    logic                win_vld_d;
    logic [ID_W-1:0]     win_id_d;
    logic [ID_W-1:0]     cand_id;
    logic [DATA_W-1:0]   win_data_s;
    logic [DATA_W-1:0]   own_data_s;
    logic [ID_W-1:0]     nxt_ptr_s;
    logic [7:0]          hold_inc_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

    // Round-robin search: descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        cand_id   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (int'(rr_ptr_q) + k >= NUM_REQ) begin
                cand_id = ID_W'(int'(rr_ptr_q) + k - NUM_REQ);
            end else begin
                cand_id = ID_W'(int'(rr_ptr_q) + k);
            end
            if (req_valid_i[cand_id]) begin
                win_vld_d = 1'b1;
                win_id_d  = cand_id;
            end
        end
    end

    assign win_data_s = req_data_i[int'(win_id_d)*DATA_W +: DATA_W];
    assign own_data_s = req_data_i[int'(gnt_id_q)*DATA_W +: DATA_W];
    assign nxt_ptr_s  = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
    assign hold_inc_s = hold_cnt_q + 8'd1;

    // Arbitration FSM with all handshake outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            gnt_valid_q <= 1'b0;
            pkt_abort_q <= 1'b0;
            last_q      <= 1'b0;
            hold_cnt_q  <= 8'd0;
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            pkt_abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gnt_valid_q <= 1'b0;
                    if (arb_en_i && !tx_busy_i && win_vld_d) begin
                        gnt_id_q    <= win_id_d;
                        tx_data_q   <= win_data_s;
                        last_q      <= req_last_i[win_id_d];
                        tx_start_q  <= 1'b1;
                        req_ready_q <= onehot(win_id_d);
                        gnt_valid_q <= 1'b1;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_SETTLE;
                end
                // uart_tx raises busy one cycle after tx_start, so busy is not trusted here.
                ST_SETTLE: begin
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (last_q) begin
                            rr_ptr_q    <= nxt_ptr_s;
                            gnt_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            hold_cnt_q <= 8'd0;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 8'(HOLD_TIMEOUT)) begin
                        rr_ptr_q    <= nxt_ptr_s;
                        gnt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (!arb_en_i) begin
                        state_q <= ST_HOLD;
                    end else if (req_valid_i[gnt_id_q]) begin
                        tx_data_q   <= own_data_s;
                        last_q      <= req_last_i[gnt_id_q];
                        tx_start_q  <= 1'b1;
                        req_ready_q <= onehot(gnt_id_q);
                        hold_cnt_q  <= 8'd0;
                        state_q     <= ST_START;
                    end else begin
                        // Abort pulse lands on the cycle the counter shows the timeout value.
                        hold_cnt_q  <= hold_inc_s;
                        pkt_abort_q <= (hold_inc_s == 8'(HOLD_TIMEOUT));
                    end
                end
                default: begin
                    gnt_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = gnt_id_q;
    assign pkt_abort_o = pkt_abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: behavioural uart_tx busy model,
// per-requester byte queues and a scoreboard of expected (id, byte) transmissions.
module tb_uart_tx_arb;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int HOLD_TIMEOUT = 16;
    localparam int FRAME        = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        pkt_abort;

    int busy_cnt = 0;

    uart_tx_arb #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .arb_en_i(arb_en),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_busy_i(tx_busy), .tx_start_o(tx_start),
        .tx_data_o(tx_data), .gnt_valid_o(gnt_valid), .gnt_id_o(gnt_id),
        .pkt_abort_o(pkt_abort)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy from the cycle after tx_start for FRAME cycles.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [8:0] pmem [NUM_REQ][16];
    int         rd_p [NUM_REQ];
    int         wr_p [NUM_REQ];
    int         rdy_cnt [NUM_REQ];
    logic [9:0] exp_q [$];

    int n_vec = 0, n_err = 0, cyc = 0, fall_cyc = 0;
    int start_cnt = 0, abort_cnt = 0, abort_gap = 0;
    bit fall_vld = 1'b0, gap_chk = 1'b0, prev_busy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        logic [8:0] w;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_p[i] < wr_p[i]) begin
                w = pmem[i][rd_p[i]];
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = w[7:0];
                req_last[i]         = w[8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int id, input logic [7:0] d, input logic l);
        pmem[id][wr_p[id]] = {l, d};
        wr_p[id]++;
    endtask

    task automatic expect_tx(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (rd_p[i] < wr_p[i]) p = 1'b1;
        return p;
    endfunction

    // One clock: sample at negedge, then update requester drives after the edge.
    task automatic cycle();
        logic [3:0] fire;
        logic [9:0] e;
        @(negedge clk);
        cyc++;
        fire = req_ready & req_valid;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (prev_busy && !tx_busy) begin
            fall_cyc = cyc;
            fall_vld = 1'b1;
        end
        prev_busy = tx_busy;
        if (tx_start === 1'b1) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("tx_data", tx_data, e[7:0]);
                check_val("gnt_id", gnt_id, e[9:8]);
                check_val("req_ready", req_ready, 4'b0001 << e[9:8]);
                check_val("gnt_valid_at_start", gnt_valid, 1);
            end
            if (gap_chk && fall_vld) check_val("frame_gap", cyc - fall_cyc, 2);
        end
        if (pkt_abort === 1'b1) begin
            abort_cnt++;
            abort_gap = cyc - fall_cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (fire[i]) rd_p[i]++;
        drive_reqs();
    endtask

    task automatic begin_test(input bit gap);
        gap_chk  = gap;
        fall_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || gnt_valid || tx_busy || pending()) && n < budget) begin
            cycle();
            n++;
        end
        check_val({tag, "_completed"}, (n < budget), 1);
        check_val({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic wait_start(input string tag);
        int s = start_cnt;
        int n = 0;
        while (start_cnt == s && n < 50) begin
            cycle();
            n++;
        end
        check_val({tag, "_start_seen"}, start_cnt - s, 1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
        exp_q.delete();
        drive_reqs();
        cycle();
        check_val({tag, "_rst_ctl"}, {tx_start, req_ready, gnt_valid, gnt_id, pkt_abort}, 0);
        check_val({tag, "_rst_data"}, tx_data, 0);
        rst = 1'b0;
        fall_vld  = 1'b0;
        prev_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, a0;
        rst = 1'b1; arb_en = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        do_reset("init");

        // Single requester, three-byte packet.
        begin_test(1'b1);
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        expect_tx(0, 8'h41); expect_tx(0, 8'h42); expect_tx(0, 8'h43);
        drive_reqs();
        drain("t1", 200);
        check_val("t1_ready_pulses", rdy_cnt[0], 3);
        check_val("t1_gnt_valid_low", gnt_valid, 0);

        // Pointer now at 1: requester 1 must beat requester 0.
        begin_test(1'b1);
        push_byte(0, 8'h50, 1'b1); push_byte(1, 8'h51, 1'b1);
        expect_tx(1, 8'h51); expect_tx(0, 8'h50);
        drive_reqs();
        drain("t1rr", 200);

        // All four requesters at once after reset.
        do_reset("t2");
        begin_test(1'b1);
        for (int i = 0; i < NUM_REQ; i++) begin
            push_byte(i, 8'h10 + 8'(i), 1'b1);
            expect_tx(i, 8'h10 + 8'(i));
        end
        drive_reqs();
        drain("t2", 400);

        // Packet lock: requester 1 keeps the grant while requester 0 waits.
        begin_test(1'b1);
        push_byte(1, 8'h21, 1'b0); push_byte(1, 8'h22, 1'b1);
        expect_tx(1, 8'h21); expect_tx(1, 8'h22); expect_tx(0, 8'h30);
        drive_reqs();
        wait_start("t3");
        push_byte(0, 8'h30, 1'b1);
        drive_reqs();
        drain("t3", 300);

        // Hold timeout on requester 2; requester 3 is next.
        begin_test(1'b0);
        abort_cnt = 0;
        push_byte(2, 8'h52, 1'b0); push_byte(3, 8'h63, 1'b1);
        expect_tx(2, 8'h52); expect_tx(3, 8'h63);
        drive_reqs();
        drain("t4", 300);
        check_val("t4_abort_count", abort_cnt, 1);
        check_val("t4_abort_delay", abort_gap, HOLD_TIMEOUT + 1);

        // arb_en low mid-packet: frame finishes, no start, no timeout.
        begin_test(1'b0);
        push_byte(0, 8'h71, 1'b0); push_byte(0, 8'h72, 1'b1);
        expect_tx(0, 8'h71); expect_tx(0, 8'h72);
        drive_reqs();
        wait_start("t5");
        arb_en = 1'b0;
        s0 = start_cnt; a0 = abort_cnt;
        repeat (40) cycle();
        check_val("t5_no_start", start_cnt - s0, 0);
        check_val("t5_no_abort", abort_cnt - a0, 0);
        check_val("t5_frame_done", tx_busy, 0);
        check_val("t5_grant_kept", gnt_valid, 1);
        arb_en = 1'b1;
        cycle(); cycle();
        check_val("t5_resume", start_cnt - s0, 1);
        drain("t5", 200);

        // Reset right after tx_start, then a fresh grant from requester 0.
        begin_test(1'b0);
        push_byte(1, 8'h81, 1'b1);
        expect_tx(1, 8'h81);
        drive_reqs();
        wait_start("t6");
        do_reset("t6");
        begin_test(1'b1);
        push_byte(0, 8'h90, 1'b1); push_byte(2, 8'hA2, 1'b1);
        expect_tx(0, 8'h90); expect_tx(2, 8'hA2);
        drive_reqs();
        drain("t6", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin, packet-locking arbiter that shares the single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesters and `uart_tx` inside `uart_top`, on the same `clk`/`rst` as the UART interface. It sequences one byte at a time into the transmitter and holds the grant until the requester's packet ends. It releases a stalled requester after a hold timeout.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width, matches `uart_tx`.
- `HOLD_TIMEOUT`, 16: cycles a granted requester may leave `req_valid` low mid-packet before the grant is revoked, 1..255.

- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `arb_en`  in  1  when low, no new byte is started; a byte already in flight completes.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  the offered byte is the final byte of the packet.
- `req_ready`  out  NUM_REQ  one-hot, 1-cycle pulse; the byte is transferred when valid&ready are high at a clock edge.
- `tx_busy`  in  1  from `uart_tx`; high while a frame is being shifted.
- `tx_start`  out  1  1-cycle pulse to `uart_tx`.
- `tx_data`  out  DATA_W  byte for `uart_tx`; stable from `tx_start` until the next `tx_start`.
- `gnt_valid`  out  1  a requester currently owns the transmitter.
- `gnt_id`  out  clog2(NUM_REQ)  owning requester index.
- `pkt_abort`  out  1  1-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, START, SETTLE, WAIT_DONE, HOLD.
- IDLE:
  - `gnt_valid`=0.
  - When `arb_en` && !`tx_busy` && |`req_valid`: select the first set `req_valid` bit searching from `rr_ptr` upward with wrap.
  - Register `gnt_id`, `tx_data`=`req_data[winner]`, `last_q`=`req_last[winner]`; go to START.
- START, 1 cycle: `tx_start`=1, `req_ready[gnt_id]`=1, `gnt_valid`=1; go to SETTLE.
- SETTLE, 1 cycle: `tx_busy` is ignored; go to WAIT_DONE.
- WAIT_DONE: stay while `tx_busy`=1. On `tx_busy`=0:
  - if `last_q`: `rr_ptr`←`gnt_id`+1 (wrap at NUM_REQ), go to IDLE;
  - else go to HOLD with the hold counter cleared.
- HOLD, grant kept, `gnt_valid`=1:
  - `arb_en`=0: stay; the counter does not advance.
  - `req_valid[gnt_id]`=1: capture data and last, go to START, counter cleared.
  - Otherwise the counter increments. When the counter reaches HOLD_TIMEOUT: `pkt_abort` pulses, `rr_ptr`←`gnt_id`+1, go to IDLE.
- Other requesters' `req_valid` are ignored while a grant is held.
- Requesters must hold `req_data`/`req_last` stable while `req_valid` is high until `req_ready`.
- Reset:
  - State IDLE, `rr_ptr`=0.
  - All outputs 0: `tx_start`, `tx_data`, `req_ready`, `gnt_valid`, `gnt_id`, `pkt_abort`.
  - Reset mid-frame abandons the byte. `uart_tx` shares `rst`, so no partial handshake survives.

## Timing
- Request seen in IDLE at cycle 0 → `tx_start`/`req_ready` high at cycle 1 → SETTLE at cycle 2 → WAIT_DONE from cycle 3.
- `uart_tx` raises `tx_busy` the cycle after it samples `tx_start`. SETTLE covers that gap.
- Back-to-back bytes in one packet: `tx_busy` first low at cycle t in WAIT_DONE → HOLD at t+1 → `tx_start` at t+2. Gap between frames is 2 idle cycles.
- New packet after a last byte: IDLE at t+1 → `tx_start` at t+2, identical gap.
- Timeout: with valid low from HOLD entry at cycle h, `pkt_abort` is high at cycle h+HOLD_TIMEOUT and IDLE follows at h+HOLD_TIMEOUT+1.
- Simultaneous requests are resolved only in IDLE; the pointer rotates only on packet end or abort.
- `tx_busy` high in IDLE (e.g. after reset) blocks arbitration.

## Test plan
- Single requester 0 sends 3-byte packet 0x41,0x42,0x43 (last on 0x43), loopback with `uart_rx` → `uart_rx` receives 0x41,0x42,0x43. `req_ready[0]` pulses 3 times. `gnt_valid` drops after the third frame. `rr_ptr`=1.
- All 4 requesters assert 1-byte packets 0x10..0x13 in the same cycle after reset → bytes transmitted in order 0x10,0x11,0x12,0x13. Each `tx_start` is 2 cycles after the previous `tx_busy` falls.
- Requester 1 owns a 2-byte packet while requester 0 also requests → both requester-1 bytes are sent before requester 0's. `gnt_id` stays 1 throughout.
- Requester 2 sends a non-last byte, then drops `req_valid` → `pkt_abort` pulses exactly HOLD_TIMEOUT=16 cycles after HOLD entry. The next grant goes to requester 3 if it is requesting.
- `arb_en`=0 during WAIT_DONE with the packet incomplete → the current frame finishes. No `tx_start` and no timeout while disabled. Re-enabling resumes within 1 cycle.
- Assert `rst` on the cycle after `tx_start` → the next cycle shows all outputs 0, state IDLE, `rr_ptr`=0. A fresh request is granted starting from requester 0.
